// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder sharing one full_adder over WIDTH cycles, LSB first (optional ovf output via SERIAL_ADD_OVF_EN)
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] sha_q, sha_d, shb_q, shb_d, acc_q, acc_d, sum_q, sum_d, acc_nx;
  logic             carry_q, carry_d, cout_q, cout_d, fa_s, fa_co, last;
  logic [CW-1:0]    cnt_q, cnt_d;
`ifdef SERIAL_ADD_OVF_EN
  logic             ovf_q, ovf_d;
  assign ovf = ovf_q;
`endif
  full_adder u_fa (.a(sha_q[0]), .b(shb_q[0]), .ci(carry_q), .s(fa_s), .co(fa_co));
  assign last   = cnt_q == CW'(WIDTH - 1);
  assign acc_nx = (acc_q >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));
  assign sum    = sum_q;
  assign cout   = cout_q;
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  // next state: DONE always falls back to IDLE, start only matters in IDLE
  always_comb
    state_d = state_q == IDLE ? (start ? RUN : IDLE) :
              state_q == RUN  ? (last ? DONE : RUN) : IDLE;
  // handshake outputs decoded from state
  always_comb begin
    busy = state_q == RUN;
    done = state_q == DONE;
  end
  // datapath next values: load on accepted start, shift one bit per RUN cycle, publish on the last bit
  always_comb begin
    sha_d   = sha_q;
    shb_d   = shb_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
`ifdef SERIAL_ADD_OVF_EN
    ovf_d   = ovf_q;
`endif
    if (state_q == IDLE && start) begin
      sha_d   = a;
      shb_d   = b;
      acc_d   = '0;
      carry_d = cin;
      cnt_d   = '0;
    end else if (state_q == RUN) begin
      sha_d   = sha_q >> 1;
      shb_d   = shb_q >> 1;
      acc_d   = acc_nx;
      carry_d = fa_co;
      cnt_d   = last ? cnt_q : cnt_q + CW'(1);
      sum_d   = last ? acc_nx : sum_q;
      cout_d  = last ? fa_co : cout_q;
`ifdef SERIAL_ADD_OVF_EN
      ovf_d   = last ? carry_q ^ fa_co : ovf_q;
`endif
    end
  end
  // datapath registers
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sha_q   <= '0;
      shb_q   <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      sha_q   <= sha_d;
      shb_q   <= shb_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: directed scoreboard bench for serial_add_ctrl at WIDTH 8 and WIDTH 1
module tb_serial_add_ctrl;
  logic       clk = 1'b0, rst = 1'b1;
  logic       start = 1'b0, cin = 1'b0, busy, done, cout;
  logic [7:0] a = '0, b = '0, sum;
  logic       start1 = 1'b0, a1 = 1'b0, b1 = 1'b0, c1 = 1'b0, busy1, done1, sum1, cout1;
  logic       ovf, ovf1;
  int         n_cmp = 0, n_bad = 0;
  logic [9:0] q8[$];
  logic [2:0] q1[$];

  serial_add_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
`ifdef SERIAL_ADD_OVF_EN
    , .ovf(ovf)
`endif
  );
  serial_add_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(c1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
`ifdef SERIAL_ADD_OVF_EN
    , .ovf(ovf1)
`endif
  );
`ifndef SERIAL_ADD_OVF_EN
  assign ovf  = 1'b0;
  assign ovf1 = 1'b0;
`endif

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] model8(input logic [7:0] x, input logic [7:0] y, input logic c);
    logic [8:0] f;
    f = {1'b0, x} + {1'b0, y} + 9'(c);
    return {(x[7] == y[7]) && (f[7] != x[7]), f};
  endfunction

  task automatic kick(input logic [7:0] x, input logic [7:0] y, input logic c, input bit push);
    a = x; b = y; cin = c; start = 1'b1;
    if (push) q8.push_back(model8(x, y, c));
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int lat);
    int n = 0, nb = 0;
    logic [9:0] e;
    while (done !== 1'b1 && n < 40) begin
      if (busy === 1'b1) nb++;
      n++;
      @(negedge clk);
    end
    check({tag, " done"}, 64'(done), 64'(1));
    check({tag, " latency"}, 64'(n), 64'(lat));
    check({tag, " busy cycles"}, 64'(nb), 64'(lat));
    check({tag, " scoreboard has entry"}, 64'(q8.size() > 0), 64'(1));
    e = q8.size() > 0 ? q8.pop_front() : 10'h3ff;
    check({tag, " cout,sum"}, 64'({cout, sum}), 64'(e[8:0]));
`ifdef SERIAL_ADD_OVF_EN
    check({tag, " ovf"}, 64'(ovf), 64'(e[9]));
`endif
    @(negedge clk);
    check({tag, " done one cycle"}, 64'({done, busy}), 64'(0));
  endtask

  initial begin
    int n, pulses;
    logic [2:0] e1;
    repeat (2) @(negedge clk);
    check("reset outputs", 64'({busy, done, sum, cout, ovf}), 64'(0));
    rst = 1'b0;
    @(negedge clk);
    kick(8'h5a, 8'h3c, 1'b0, 1); wait_done("5a+3c", 8);
    kick(8'hff, 8'h01, 1'b0, 1); wait_done("ff+01", 8);
    kick(8'hff, 8'h00, 1'b1, 1); wait_done("ff+00+1", 8);
    kick(8'h00, 8'h00, 1'b1, 1); wait_done("00+00+1", 8);
    kick(8'h10, 8'h20, 1'b0, 1);
    a = 8'haa; b = 8'h55; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = 8'h77; b = 8'h99; cin = 1'b1;
    check("sum held during run", 64'({cout, sum}), 64'(9'h001));
    wait_done("10+20 ignore", 7);
    pulses = 0;
    repeat (12) begin
      if (done === 1'b1) pulses++;
      @(negedge clk);
    end
    check("no done from ignored start", 64'(pulses), 64'(0));
    check("scoreboard empty", 64'(q8.size()), 64'(0));
    kick(8'h11, 8'h22, 1'b0, 0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1 check("async reset outputs", 64'({busy, done, sum, cout, ovf}), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    repeat (15) begin
      if (done === 1'b1) pulses++;
      @(negedge clk);
    end
    check("no done after abort", 64'(pulses), 64'(0));
    kick(8'h12, 8'h34, 1'b1, 1); wait_done("12+34+1 after reset", 8);
    kick(8'h7f, 8'h01, 1'b0, 1); wait_done("7f+01", 8);
    kick(8'h80, 8'h80, 1'b0, 1); wait_done("80+80", 8);
    kick(8'h05, 8'h03, 1'b0, 1); wait_done("05+03", 8);
    for (int i = 0; i < 8; i++) begin
      a1 = i[2]; b1 = i[1]; c1 = i[0]; start1 = 1'b1;
      q1.push_back({(i[2] == i[1]) && ((i[2] ^ i[1] ^ i[0]) != i[2]), 2'(i[2]) + 2'(i[1]) + 2'(i[0])});
      @(negedge clk);
      start1 = 1'b0;
      n = 0;
      while (done1 !== 1'b1 && n < 10) begin
        n++;
        @(negedge clk);
      end
      e1 = q1.pop_front();
      check($sformatf("w1 abc=%0d latency", i), 64'(n), 64'(1));
      check($sformatf("w1 abc=%0d cout,sum", i), 64'({cout1, sum1}), 64'(e1[1:0]));
`ifdef SERIAL_ADD_OVF_EN
      check($sformatf("w1 abc=%0d ovf", i), 64'(ovf1), 64'(e1[2]));
`endif
      @(negedge clk);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
Bit-serial adder controller. It sequences one instance of the team's 1-bit full_adder over WIDTH clock cycles, LSB first, to add two WIDTH-bit operands. A carry register closes the loop between cycles. It uses a start/busy/done handshake so an area-constrained datapath can share a single full-adder cell instead of a ripple chain.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 1..32.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-high reset
start  input  1  request pulse; sampled only in IDLE
a  input  WIDTH  operand A; captured on accepted start
b  input  WIDTH  operand B; captured on accepted start
cin  input  1  carry-in; captured on accepted start
busy  output  1  high while a serial add is in progress
done  output  1  one-cycle pulse when sum/cout become valid
sum  output  WIDTH  registered result; held until the next completion
cout  output  1  registered final carry-out; held with sum

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset state:
  - state = IDLE
  - busy = 0, done = 0, sum = 0, cout = 0
  - internal shift registers, carry register and bit counter cleared.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - On an edge with start = 1: load shA <= a, shB <= b, carry <= cin, cnt <= 0, go to RUN.
  - With start = 0: stay in IDLE.
- RUN (busy = 1):
  - Drive the full_adder with shA[0], shB[0] and carry.
  - Each edge: shA and shB shift right by 1; the adder's sum bit enters the MSB of the result shift register (acc), which shifts right.
  - Each edge: carry <= adder cout; cnt <= cnt + 1.
  - When cnt == WIDTH-1 at an edge: the last bit is processed, sum <= final acc value (including this bit), cout <= adder cout, go to DONE.
- DONE: done = 1, busy = 0 for exactly one cycle, then unconditionally go to IDLE.
- Latency: start accepted at edge E0. busy is high for cycles E0..E(WIDTH). done is high in the cycle after edge E(WIDTH). Total is WIDTH+1 cycles from start to done.
- Operand capture: a, b and cin are captured only at acceptance. Changes while busy have no effect.
- start in RUN or DONE: ignored, not queued. start must be reasserted in IDLE.
- Output hold: sum/cout change only at the RUN->DONE edge. They keep the previous result throughout RUN.
- Counter width: $clog2(WIDTH+1) bits. No wrap beyond WIDTH-1.
- WIDTH = 1: exactly one RUN cycle. The result equals a single full_adder evaluation.
- Arithmetic: {cout, sum} == a + b + cin, modulo 2^(WIDTH+1).
- Reset mid-operation: aborts immediately (asynchronous). Outputs return to reset values and no done pulse is produced.

Optional Feature:
Macro SERIAL_ADD_OVF_EN.
- When defined: adds output port ovf (1 bit), registered alongside cout.
  - ovf = carry into the MSB XOR carry out of the MSB, i.e. signed two's-complement overflow.
  - Reset value 0. Held until the next completion.
- When undefined: the port and its logic are absent. All other behaviour is unchanged.

Test Plan:
- WIDTH = 8, a = 0x5A, b = 0x3C, cin = 0, start pulse -> busy high for 8 cycles, done pulse 9 cycles after start, sum = 0x96, cout = 0.
- a = 0xFF, b = 0x01, cin = 0 -> sum = 0x00, cout = 1. Then a = 0xFF, b = 0x00, cin = 1 -> sum = 0x00, cout = 1. Then a = 0x00, b = 0x00, cin = 1 -> sum = 0x01, cout = 0.
- Start an add of 0x10+0x20, then pulse start with a = 0xAA, b = 0x55 while busy; also change a and b mid-run -> single done, sum = 0x30. Second start produces no further done.
- Assert rst asynchronously (mid-cycle) 3 cycles into RUN -> busy, done, sum and cout read 0 immediately. No done pulse follows. The next start after deassert completes normally.
- Exhaustive WIDTH = 1 sweep over all 8 {a, b, cin} combinations -> {cout, sum} equals the arithmetic sum for each, with one-cycle RUN each time.
- With SERIAL_ADD_OVF_EN: a = 0x7F, b = 0x01 -> sum = 0x80, ovf = 1, cout = 0. a = 0x80, b = 0x80 -> sum = 0x00, ovf = 1, cout = 1. a = 0x05, b = 0x03 -> ovf = 0.
